read_d12: RTL and testbench
===========================

# read_d12

Front-end sample reader for the acquisition path. It assembles two serial-read bytes into a 16-bit sample word and splits the word into a 6-bit channel tag and a 10-bit data value. It also buffers 10-bit samples in an 8-deep FIFO. On every accepted write it maintains a running sum of buffered samples and flags samples that exceed a programmable threshold (peak detect).

## Interface
- NUM_BITS, 10, sample data width
- DEPTH, 8, FIFO depth in words (power of two)
- CW, clog2(DEPTH)+1 = 4, width of fifo_counter
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- reg1  in  8  first (high) byte of the sample word
- reg2  in  8  second (low) byte of the sample word
- concat_data1  out  16  combinational {reg1, reg2}
- channel_op  out  6  registered channel tag, bits [15:10] of the word
- data_op  out  NUM_BITS  registered data value, bits [9:0] of the word
- wr_en1  in  1  FIFO write request
- rd_en1  in  1  FIFO read request
- fifo_in  in  NUM_BITS  FIFO write data
- fifo_out  out  NUM_BITS  registered FIFO read data
- empty  out  1  FIFO holds 0 words
- full  out  1  FIFO holds DEPTH words
- fifo_counter  out  CW  number of stored words (0..DEPTH)
- Threshold  in  NUM_BITS  peak threshold, unsigned
- sum  out  NUM_BITS+7  running sum of words currently stored
- peak  out  NUM_BITS  last sample that exceeded Threshold
- peak_valid  out  1  one-cycle pulse when peak is updated

## Operation
- Unpack: concat_data1 = {reg1, reg2}, combinational. Each rising edge: channel_op <= concat_data1[15:10], data_op <= concat_data1[9:0].
- FIFO storage: DEPTH x NUM_BITS, with CW-1-bit read and write pointers that wrap modulo DEPTH.
- Write acceptance: a write is accepted when wr_en1 = 1 and full = 0. On acceptance, mem[wr_ptr] <= fifo_in and wr_ptr increments.
- Read acceptance: a read is accepted when rd_en1 = 1 and empty = 0. On acceptance, fifo_out <= mem[rd_ptr] and rd_ptr increments. Otherwise fifo_out holds its value.
- Acceptance evaluates against the flags before the edge:
  - Full with both requests: only the read is accepted.
  - Empty with both requests: only the write is accepted.
  - Otherwise both are accepted and fifo_counter is unchanged.
- fifo_counter: +1 on write only, -1 on read only, unchanged otherwise. empty = (fifo_counter == 0) and full = (fifo_counter == DEPTH), both decoded combinationally from the counter.
- Rejected requests leave all state unchanged.
- sum: on each edge, sum <= sum + (accepted write ? fifo_in : 0) - (accepted read ? word read : 0). Zero-extend both terms; sum cannot overflow (maximum 8 x 1023).
- Peak: on an accepted write with fifo_in > Threshold (unsigned, strict), peak <= fifo_in and peak_valid <= 1. Otherwise peak_valid <= 0 and peak holds. fifo_in == Threshold is not a peak. A rejected write (FIFO full) never flags.
- Reset (rst_n low, asynchronous): pointers, fifo_counter, channel_op, data_op, fifo_out, sum, peak and peak_valid all go to 0; empty = 1, full = 0. Memory contents are not cleared. Reset asserted mid-operation discards all stored words immediately.

## Timing
- Unpack latency: 1 cycle from reg1/reg2 to channel_op/data_op. concat_data1 has 0 cycles of latency.
- Write then read: a word written at edge N is readable at edge N+1, because empty deasserts after edge N.
- Read data: fifo_out is valid immediately after the edge that accepts the read, and is stable until the next accepted read.
- Flags and fifo_counter update at the same edge as the accepted operation.
- sum, peak and peak_valid update at the accepting edge. peak_valid is high for exactly one cycle per qualifying write.
- Back-to-back qualifying writes keep peak_valid high continuously, with peak updating every cycle.

## Test plan
- Reset: assert rst_n = 0 mid-stream with 3 words stored. Required: empty = 1, full = 0, fifo_counter = 0, sum = 0, fifo_out = 0, peak_valid = 0, asynchronously and before the next edge.
- Unpack: reg1 = 0x12, reg2 = 0x34. Required: concat_data1 = 0x1234 at once; channel_op = 4 and data_op = 0x234 (564) after one edge.
- Fill and overflow: write 1..8. Required: full = 1, fifo_counter = 8, sum = 36. Then write 9. Required: ignored; counter stays 8, sum stays 36. Then read 8 times. Required: outputs 1..8 in order, then empty = 1 and sum = 0. A 9th read leaves fifo_out = 8.
- Simultaneous read/write:
  - With 4 stored, assert both requests for 5 cycles. Required: counter stays 4 and FIFO order is preserved.
  - At empty with both requests: only the write is accepted (counter = 1).
  - At full with both requests: only the read is accepted (counter = 7).
- Peak: Threshold = 456. Write 456. Required: no pulse. Write 457. Required: peak_valid pulses, peak = 457. Write 564 then 100. Required: one pulse, peak = 564, held after the write of 100.
- Pointer wrap: perform 20 interleaved write/read operations crossing address 7 to 0. Required: data integrity and correct counter/sum throughout.

Source files
------------

// File: rtl/read_d12.sv
// Sample reader: unpacks a two-byte sample word into channel tag and data value, and buffers
// samples in a small FIFO that tracks a running sum and detects samples above a threshold.
module read_d12 #(
    parameter int unsigned NUM_BITS = 10,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CW       = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            reg1,
    input  logic [7:0]            reg2,
    output logic [15:0]           concat_data1,
    output logic [5:0]            channel_op,
    output logic [NUM_BITS-1:0]   data_op,
    input  logic                  wr_en1,
    input  logic                  rd_en1,
    input  logic [NUM_BITS-1:0]   fifo_in,
    output logic [NUM_BITS-1:0]   fifo_out,
    output logic                  empty,
    output logic                  full,
    output logic [CW-1:0]         fifo_counter,
    input  logic [NUM_BITS-1:0]   Threshold,
    output logic [NUM_BITS+6:0]   sum,
    output logic [NUM_BITS-1:0]   peak,
    output logic                  peak_valid
);

    localparam int unsigned PW = CW - 1;
    localparam int unsigned SW = NUM_BITS + 7;

    logic [NUM_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic [SW-1:0]       sum_q, sum_d;
    logic [NUM_BITS-1:0] fifo_out_q, peak_q;
    logic                peak_valid_q;
    logic [5:0]          channel_q;
    logic [NUM_BITS-1:0] data_q;
    logic                wr_acc, rd_acc;

    assign concat_data1 = {reg1, reg2};

    // Acceptance uses the flags as they stand before the edge.
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign wr_acc = wr_en1 & ~full;
    assign rd_acc = rd_en1 & ~empty;

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        sum_d = sum_q;
        if (wr_acc) sum_d = sum_d + SW'(fifo_in);
        if (rd_acc) sum_d = sum_d - SW'(mem[rd_ptr_q]);
    end

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= fifo_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sum_q        <= '0;
            fifo_out_q   <= '0;
            peak_q       <= '0;
            peak_valid_q <= 1'b0;
            channel_q    <= '0;
            data_q       <= '0;
        end else begin
            channel_q    <= concat_data1[15:10];
            data_q       <= NUM_BITS'(concat_data1[9:0]);
            count_q      <= count_d;
            sum_q        <= sum_d;
            if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_acc) begin
                rd_ptr_q   <= rd_ptr_q + PW'(1);
                fifo_out_q <= mem[rd_ptr_q];
            end
            peak_valid_q <= wr_acc && (fifo_in > Threshold);
            if (wr_acc && (fifo_in > Threshold)) peak_q <= fifo_in;
        end
    end

    assign channel_op   = channel_q;
    assign data_op      = data_q;
    assign fifo_out     = fifo_out_q;
    assign fifo_counter = count_q;
    assign sum          = sum_q;
    assign peak         = peak_q;
    assign peak_valid   = peak_valid_q;

endmodule

// File: tb/tb_read_d12.sv
// Randomised and directed bench for read_d12 against a queue-based reference model.
module tb_read_d12;

    logic        clk, rst_n;
    logic [7:0]  reg1, reg2;
    logic [15:0] concat_data1;
    logic [5:0]  channel_op;
    logic [9:0]  data_op, fifo_in, fifo_out, Threshold, peak;
    logic        wr_en1, rd_en1, empty, full, peak_valid;
    logic [3:0]  fifo_counter;
    logic [16:0] sum;

    read_d12 dut (
        .clk(clk), .rst_n(rst_n), .reg1(reg1), .reg2(reg2), .concat_data1(concat_data1),
        .channel_op(channel_op), .data_op(data_op), .wr_en1(wr_en1), .rd_en1(rd_en1),
        .fifo_in(fifo_in), .fifo_out(fifo_out), .empty(empty), .full(full),
        .fifo_counter(fifo_counter), .Threshold(Threshold), .sum(sum), .peak(peak),
        .peak_valid(peak_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int q[$];
    int out_m, peak_m, pv_m, ch_m, dat_m;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int q_sum();
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic check_state();
        check_eq("fifo_counter", fifo_counter, q.size());
        check_eq("empty", empty, q.size() == 0);
        check_eq("full", full, q.size() == 8);
        check_eq("sum", sum, q_sum());
        check_eq("fifo_out", fifo_out, out_m);
        check_eq("peak", peak, peak_m);
        check_eq("peak_valid", peak_valid, pv_m);
        check_eq("channel_op", channel_op, ch_m);
        check_eq("data_op", data_op, dat_m);
    endtask

    // One clock: drive at posedge+1, check concat, take the edge, update model, check at posedge+1.
    task automatic step(input bit wr, input bit rd, input int din, input int thr,
                        input int r1 = -1, input int r2 = -1);
        bit wacc, racc;
        int word;
        reg1      = (r1 < 0) ? 8'($urandom) : 8'(r1);
        reg2      = (r2 < 0) ? 8'($urandom) : 8'(r2);
        wr_en1    = wr;
        rd_en1    = rd;
        fifo_in   = 10'(din);
        Threshold = 10'(thr);
        word      = {reg1, reg2};
        #1;
        check_eq("concat_data1", concat_data1, word);
        wacc = wr && (q.size() < 8);
        racc = rd && (q.size() > 0);
        @(posedge clk);
        #1;
        if (racc) out_m = q.pop_front();
        if (wacc) q.push_back(din);
        pv_m = (wacc && din > thr) ? 1 : 0;
        if (pv_m == 1) peak_m = din;
        ch_m  = word / 1024;
        dat_m = word % 1024;
        check_state();
    endtask

    task automatic model_reset();
        q.delete();
        out_m = 0; peak_m = 0; pv_m = 0; ch_m = 0; dat_m = 0;
    endtask

    initial begin
        rst_n = 1'b0; reg1 = '0; reg2 = '0; wr_en1 = 0; rd_en1 = 0; fifo_in = '0; Threshold = '0;
        model_reset();
        #2;
        check_state();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Unpack
        step(0, 0, 0, 1023, 8'h12, 8'h34);
        check_eq("unpack_channel", channel_op, 4);
        check_eq("unpack_data", data_op, 564);

        // Fill, overflow, drain, extra read
        for (int i = 1; i <= 8; i++) step(1, 0, i, 1023);
        check_eq("fill_full", full, 1);
        check_eq("fill_sum", sum, 36);
        step(1, 0, 9, 1023);
        check_eq("ovf_counter", fifo_counter, 8);
        check_eq("ovf_sum", sum, 36);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 0, 1023);
            check_eq("drain_order", fifo_out, i);
        end
        check_eq("drain_empty", empty, 1);
        step(0, 1, 0, 1023);
        check_eq("extra_read", fifo_out, 8);

        // Simultaneous read/write with 4 stored
        for (int i = 0; i < 4; i++) step(1, 0, 10 + i, 1023);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 20 + i, 1023);
            check_eq("simul_counter", fifo_counter, 4);
        end
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1023);
        check_eq("simul_order", fifo_out, 24);
        // Both at empty, then both at full
        step(1, 1, 77, 1023);
        check_eq("empty_both", fifo_counter, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 100 + i, 1023);
        step(1, 1, 500, 1023);
        check_eq("full_both", fifo_counter, 7);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1023);

        // Peak detect
        step(1, 0, 456, 456);
        check_eq("peak_equal", peak_valid, 0);
        step(1, 0, 457, 456);
        check_eq("peak_457_valid", peak_valid, 1);
        check_eq("peak_457", peak, 457);
        step(1, 0, 564, 456);
        check_eq("peak_564", peak, 564);
        step(1, 0, 100, 456);
        check_eq("peak_held", peak, 564);
        check_eq("peak_low_valid", peak_valid, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 456);

        // Pointer wrap: interleaved traffic
        for (int i = 0; i < 20; i++) step(i % 2 == 0 || i % 5 == 0, i % 2 == 1, $urandom_range(0, 1023), 600);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 1023), $urandom_range(0, 1023));

        // Asynchronous reset mid-stream with 3 stored
        while (q.size() > 0) step(0, 1, 0, 1023);
        for (int i = 0; i < 3; i++) step(1, 0, 900 + i, 100);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        #2;
        rst_n = 1'b1;
        step(1, 1, 33, 10);
        step(0, 1, 0, 10);
        check_eq("post_reset_read", fifo_out, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
